// File: rtl/pfram_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pfram_arbiter_if : CPU / video / RAM bus bundle for pfram_arbiter |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface pfram_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              cpu_strobe;
  logic              cpu_pfram_l;
  logic              cpu_we_l;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rdy;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic              vid_valid;
  logic [DATA_W-1:0] vid_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_strobe, cpu_pfram_l, cpu_we_l, cpu_addr, cpu_wdata,
    input  vid_req, vid_addr, ram_rdata,
    output cpu_rdata, cpu_rdy, vid_gnt, vid_valid, vid_rdata,
    output ram_addr, ram_we, ram_wdata
  );

  modport master (
    output cpu_strobe, cpu_pfram_l, cpu_we_l, cpu_addr, cpu_wdata,
    output vid_req, vid_addr, ram_rdata,
    input  cpu_rdata, cpu_rdy, vid_gnt, vid_valid, vid_rdata,
    input  ram_addr, ram_we, ram_wdata
  );
endinterface
`default_nettype wire

// File: rtl/pfram_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pfram_arbiter : playfield RAM arbiter, video priority with a     |
// | bounded run so a stalled 6502 access always completes.           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module pfram_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 8,
  parameter int MAX_VID_RUN = 3
) (
  input  logic           clk,
  input  logic           rst_l,
  pfram_arbiter_if.slave bus
);

  localparam int RUN_W = (MAX_VID_RUN > 0) ? $clog2(MAX_VID_RUN + 1) : 1;
  localparam logic [RUN_W-1:0] c_max_run = RUN_W'(MAX_VID_RUN);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_WAIT = 2'd1;
  localparam logic [1:0] C_DATA = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_hold_addr;
  logic              r_hold_we;
  logic [DATA_W-1:0] r_hold_wdata;
  logic [ADDR_W-1:0] r_last_addr;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_cpu_rdy;
  logic              r_vid_valid;
  logic [RUN_W-1:0]  r_vid_run;

  logic              w_accept;
  logic              w_vid_gnt;
  logic              w_cpu_gnt;
  logic [ADDR_W-1:0] w_ram_addr;

  assign w_accept  = bus.cpu_strobe && !bus.cpu_pfram_l && (r_state == C_IDLE);
  // Gated by rst_l so no grant (and no RAM access) is visible while reset is held.
  assign w_vid_gnt = rst_l && bus.vid_req &&
                     ((r_state != C_WAIT) || (r_vid_run < c_max_run));
  assign w_cpu_gnt = !w_vid_gnt && (r_state == C_WAIT);

  always_comb begin
    w_ram_addr = r_last_addr;
    if (w_vid_gnt)
      w_ram_addr = bus.vid_addr;
    else if (w_cpu_gnt)
      w_ram_addr = r_hold_addr;
  end

  assign bus.ram_addr  = w_ram_addr;
  assign bus.ram_we    = w_cpu_gnt && r_hold_we;
  assign bus.ram_wdata = r_hold_wdata;
  assign bus.vid_gnt   = w_vid_gnt;
  assign bus.vid_valid = r_vid_valid;
  assign bus.vid_rdata = bus.ram_rdata;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.cpu_rdy   = r_cpu_rdy;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state      <= C_IDLE;
      r_hold_addr  <= '0;
      r_hold_we    <= 1'b0;
      r_hold_wdata <= '0;
      r_last_addr  <= '0;
      r_cpu_rdata  <= '0;
      r_cpu_rdy    <= 1'b1;
      r_vid_valid  <= 1'b0;
      r_vid_run    <= '0;
    end else begin
      r_last_addr <= w_ram_addr;
      r_vid_valid <= w_vid_gnt;

      // Run length only counts video grants that actually held off a pending CPU access.
      if ((r_state == C_WAIT) && w_vid_gnt) begin
        if (r_vid_run != c_max_run)
          r_vid_run <= r_vid_run + 1'b1;
      end else begin
        r_vid_run <= '0;
      end

      case (r_state)
        C_IDLE: begin
          if (w_accept) begin
            r_hold_addr  <= bus.cpu_addr;
            r_hold_we    <= !bus.cpu_we_l;
            r_hold_wdata <= bus.cpu_wdata;
            r_cpu_rdy    <= 1'b0;
            r_state      <= C_WAIT;
          end
        end
        C_WAIT: begin
          if (w_cpu_gnt) begin
            if (r_hold_we) begin
              r_cpu_rdy <= 1'b1;
              r_state   <= C_IDLE;
            end else begin
              r_state <= C_DATA;
            end
          end
        end
        C_DATA: begin
          r_cpu_rdata <= bus.ram_rdata;
          r_cpu_rdy   <= 1'b1;
          r_state     <= C_IDLE;
        end
        default: r_state <= C_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
